// File: rtl/pipe_ctrl_pkg.sv
// Shared widths, exception cause codes and controller state encoding for the
// pipeline controller.
package pipe_ctrl_pkg;

  localparam int unsigned WordDataW = 32;
  localparam int unsigned ExpCodeW  = 3;

  typedef logic [WordDataW-1:0] word_data_t;
  typedef logic [ExpCodeW-1:0]  exp_code_t;

  localparam exp_code_t EXP_NO_EXP     = 3'd0;
  localparam exp_code_t EXP_EXT_INT    = 3'd1;
  localparam exp_code_t EXP_UNDEF_INSN = 3'd2;
  localparam exp_code_t EXP_OVERFLOW   = 3'd3;
  localparam exp_code_t EXP_MISS_ALIGN = 3'd4;
  localparam exp_code_t EXP_TRAP       = 3'd5;
  localparam exp_code_t EXP_PRV_VIO    = 3'd6;

  localparam word_data_t EXC_VECTOR_DEFAULT = 32'h0000_0100;

  typedef enum logic [1:0] {
    PipeRun  = 2'd0,
    PipeTrap = 2'd1,
    PipeHalt = 2'd2
  } pipe_state_e;

  function automatic logic is_exception(exp_code_t code);
    return code != EXP_NO_EXP;
  endfunction

endpackage

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline controller: per-stage stall/flush generation plus
// exception entry, exception return and double-fault halt sequencing.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_busy,
  input  logic        ld_hazard,
  input  logic        mem_busy,
  input  logic        mem_en,
  input  logic [2:0]  mem_exp_code,
  input  logic [31:0] mem_pc,
  input  logic        id_eret,
  output logic        if_stall,
  output logic        id_stall,
  output logic        ex_stall,
  output logic        mem_stall,
  output logic        if_flush,
  output logic        id_flush,
  output logic        ex_flush,
  output logic        mem_flush,
  output logic        new_pc_we,
  output logic [31:0] new_pc,
  output logic [31:0] epc,
  output logic [2:0]  exp_cause,
  output logic        in_handler,
  output logic        halted
);

  pipe_state_e state_q, state_d;
  pipe_state_e ctrl_state;
  logic [31:0] epc_q, epc_d;
  logic [2:0]  cause_q, cause_d;
  logic        in_handler_q, in_handler_d;
  logic        halted_q, halted_d;
  logic        exc_take;
  logic        eret_take;

  // While reset is asserted the controls behave as if in RUN.
  assign ctrl_state = reset ? state_q : PipeRun;
  assign exc_take   = mem_en & is_exception(mem_exp_code) & ~mem_busy;
  assign eret_take  = id_eret & (ctrl_state == PipeTrap) & ~mem_busy;

  always_comb begin
    if_stall  = 1'b0;
    id_stall  = 1'b0;
    ex_stall  = 1'b0;
    mem_stall = 1'b0;
    if_flush  = 1'b0;
    id_flush  = 1'b0;
    ex_flush  = 1'b0;
    mem_flush = 1'b0;
    new_pc_we = 1'b0;
    new_pc    = 32'h0;
    if (ctrl_state == PipeHalt) begin
      {if_stall, id_stall, ex_stall, mem_stall} = 4'hf;
    end else if (exc_take) begin
      {if_flush, id_flush, ex_flush, mem_flush} = 4'hf;
      new_pc_we = 1'b1;
      new_pc    = EXC_VECTOR;
    end else if (mem_busy) begin
      {if_stall, id_stall, ex_stall, mem_stall} = 4'hf;
    end else if (eret_take) begin
      if_flush  = 1'b1;
      id_flush  = 1'b1;
      new_pc_we = 1'b1;
      new_pc    = epc_q;
    end else if (ld_hazard) begin
      if_stall = 1'b1;
      id_stall = 1'b1;
      ex_flush = 1'b1;
    end else if (if_busy) begin
      if_stall = 1'b1;
      id_flush = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    unique case (state_q)
      PipeRun: begin
        if (exc_take) begin
          state_d = PipeTrap;
          epc_d   = mem_pc;
          cause_d = mem_exp_code;
        end
      end
      PipeTrap: begin
        // A fault inside the handler keeps the original EPC for post-mortem.
        if (exc_take) begin
          state_d = PipeHalt;
          cause_d = mem_exp_code;
        end else if (eret_take) begin
          state_d = PipeRun;
        end
      end
      PipeHalt: state_d = PipeHalt;
      default:  state_d = PipeRun;
    endcase
    in_handler_d = (state_d == PipeTrap);
    halted_d     = (state_d == PipeHalt);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= PipeRun;
      epc_q        <= 32'h0;
      cause_q      <= EXP_NO_EXP;
      in_handler_q <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      epc_q        <= epc_d;
      cause_q      <= cause_d;
      in_handler_q <= in_handler_d;
      halted_q     <= halted_d;
    end
  end

  assign epc        = epc_q;
  assign exp_cause  = cause_q;
  assign in_handler = in_handler_q;
  assign halted     = halted_q;

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline controller for the five-stage core: generates per-stage stall/flush for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and sequences exception entry and return. It watches the MEM/WB register outputs for a valid excepting instruction, redirects fetch, and records EPC and cause. It also tracks handler mode and double faults. It sits beside the datapath and drives the `stall`/`flush` inputs of every stage register.

## Interface
- `EXC_VECTOR`, `32'h0000_0100`: handler entry address.
- `clk`  in  1  core clock.
- `reset`  in  1  synchronous, active-low reset; state is cleared on the rising `clk` edge where `reset == 0`.
- `if_busy`  in  1  fetch not ready (I-side wait).
- `ld_hazard`  in  1  decode detected load-use hazard.
- `mem_busy`  in  1  D-side access outstanding.
- `mem_en`  in  1  MEM/WB register holds a valid instruction.
- `mem_exp_code`  in  `EXP_CODE_BUS`  cause carried in MEM/WB.
- `mem_pc`  in  `WORD_DATA_BUS`  PC of the MEM/WB instruction.
- `id_eret`  in  1  valid exception-return instruction in decode.
- `if_stall`, `id_stall`, `ex_stall`, `mem_stall`  out  1 each  stage-register hold.
- `if_flush`, `id_flush`, `ex_flush`, `mem_flush`  out  1 each  stage-register bubble.
- `new_pc_we`  out  1  redirect fetch this cycle.
- `new_pc`  out  `WORD_DATA_BUS`  redirect target.
- `epc`  out  `WORD_DATA_BUS`  saved exception PC (registered).
- `exp_cause`  out  `EXP_CODE_BUS`  saved cause (registered).
- `in_handler`  out  1  state == TRAP.
- `halted`  out  1  state == HALT.

## Operation
- States: RUN, TRAP, HALT. Encoding: 2 bits.
- `exc_take = mem_en & (mem_exp_code != EXP_NO_EXP) & ~mem_busy`.
- Priority within a cycle, highest first: HALT, exc_take, mem_busy, id_eret, ld_hazard, if_busy.
- HALT: all four stalls = 1, all flushes = 0, `new_pc_we = 0`. Leaves HALT only on reset.
- RUN with exc_take:
  - all four flushes = 1, all stalls = 0.
  - `new_pc_we = 1`, `new_pc = EXC_VECTOR`.
  - Next edge: `epc <= mem_pc`, `exp_cause <= mem_exp_code`, state to TRAP.
- TRAP with exc_take: double fault. Flushes/redirect are identical to RUN, `epc` is unchanged, `exp_cause <= mem_exp_code`, state to HALT.
- mem_busy (no exc_take): all four stalls = 1, no flush.
- id_eret in TRAP:
  - `if_flush = id_flush = 1`.
  - `new_pc_we = 1`, `new_pc = epc`.
  - Next edge: state to RUN.
- id_eret in RUN is ignored; decode raises the illegal cause itself.
- ld_hazard: `if_stall = id_stall = 1`, `ex_flush = 1`.
- if_busy: `if_stall = 1`, `id_flush = 1`.
- Default outputs: stalls and flushes 0, `new_pc_we = 0`, `new_pc = 0`.
- `stall` and `flush` are never both 1 for the same stage.

## Timing
- Stall, flush and `new_pc*` are combinational from inputs and state; no added latency. Excepting instruction is squashed in the same cycle it appears in MEM/WB.
- `epc`, `exp_cause` and state update on the edge after exc_take/eret.
- Reset values: state RUN, `epc = 0`, `exp_cause = EXP_NO_EXP`, `in_handler = 0`, `halted = 0`. During reset, combinational outputs follow RUN rules.
- Reset has priority over every event, including a simultaneous exc_take.
- exc_take while mem_busy is deferred until mem_busy falls. Inputs are held because all stages are stalled.
- id_eret together with exc_take: exception wins and eret is dropped (flushed).

## Structure
- Add to `base_core_defines.v`:
  - state codes `PIPE_RUN`, `PIPE_TRAP`, `PIPE_HALT`, with `PIPE_STATE_BUS`.
  - `EXC_VECTOR_DEFAULT`.
- `EXP_*` codes remain in the shared defines.
- Single module; no sub-module. One `always @(posedge clk)` for state/EPC/cause, one combinational block for controls.

## Test plan
- Reset held 0 for 2 cycles with `mem_en=1`, `mem_exp_code=EXP_MISS_ALIGN` -> state RUN, `epc=0`, no TRAP entry.
- RUN, `mem_en=1`, `mem_exp_code=EXP_MISS_ALIGN`, `mem_pc=32'h40` -> same cycle: 4 flushes = 1, `new_pc=32'h100`; next cycle: `epc=32'h40`, `in_handler=1`.
- Same exception with `mem_busy=1` for 3 cycles -> 4 stalls = 1 for 3 cycles, no flush; exception taken in the 4th cycle.
- TRAP, `id_eret=1` -> `new_pc=epc=32'h40`, `if_flush=id_flush=1`; next cycle RUN.
- TRAP plus a second exception at `mem_pc=32'h108` -> `epc` stays `32'h40`; next cycle `halted=1`, all stalls = 1 until reset.
- RUN, `ld_hazard=1` and `if_busy=1` together -> `if_stall=id_stall=ex_flush=1`, `id_flush=0`.
